// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline register feeding a shifter, with EX/MEM and MEM/WB operand
// forwarding applied combinationally on the registered source numbers.
module id_ex_shift_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [3:0]  id_opcode,
   input  logic [15:0] id_rs_data,
   input  logic [15:0] id_rt_data,
   input  logic [3:0]  id_rs,
   input  logic [3:0]  id_rt,
   input  logic [3:0]  id_rd,
   input  logic [3:0]  id_imm,
   input  logic        id_wr_en,
   input  logic        stall,
   input  logic        flush,
   input  logic [3:0]  exmem_rd,
   input  logic [3:0]  memwb_rd,
   input  logic        exmem_wr_en,
   input  logic        memwb_wr_en,
   input  logic [15:0] exmem_result,
   input  logic [15:0] memwb_result,
   output logic        ex_valid,
   output logic        ex_wr_en,
   output logic [3:0]  ex_opcode,
   output logic [3:0]  ex_rd,
   output logic [15:0] ex_op_a,
   output logic [15:0] ex_op_b,
   output logic [15:0] Shift_In,
   output logic [3:0]  Shift_Val,
   output logic        Mode
);

   localparam logic [3:0] OP_SRA = 4'b0101;

   logic        r_valid;
   logic        r_wr_en;
   logic [3:0]  r_opcode;
   logic [3:0]  r_rd;
   logic [3:0]  r_rs;
   logic [3:0]  r_rt;
   logic [15:0] r_rs_data;
   logic [15:0] r_rt_data;
   logic [3:0]  r_imm;

   logic [15:0] w_op_a;
   logic [15:0] w_op_b;

   // Flush takes precedence over stall; a bubble also clears the source
   // numbers so it can never pick up a forwarded value.
   // NOTE: non-blocking assignments keep every field sampling pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         r_valid   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_opcode  <= 4'd0;
         r_rd      <= 4'd0;
         r_rs      <= 4'd0;
         r_rt      <= 4'd0;
         r_rs_data <= 16'd0;
         r_rt_data <= 16'd0;
         r_imm     <= 4'd0;
      end else if (!stall) begin
         r_valid   <= id_valid;
         r_wr_en   <= id_valid & id_wr_en;
         r_opcode  <= id_opcode;
         r_rd      <= id_rd;
         r_rs      <= id_rs;
         r_rt      <= id_rt;
         r_rs_data <= id_rs_data;
         r_rt_data <= id_rt_data;
         r_imm     <= id_imm;
      end
   end

   function automatic logic [15:0] fwd_sel(input logic [3:0]  src,
                                           input logic [15:0] reg_data);
      if (src != 4'd0 && exmem_wr_en && exmem_rd == src)
         return exmem_result;
      else if (src != 4'd0 && memwb_wr_en && memwb_rd == src)
         return memwb_result;
      else
         return reg_data;
   endfunction

   always_comb begin
      w_op_a = fwd_sel(r_rs, r_rs_data);
      w_op_b = fwd_sel(r_rt, r_rt_data);
   end

   assign ex_valid  = r_valid;
   assign ex_wr_en  = r_wr_en;
   assign ex_opcode = r_opcode;
   assign ex_rd     = r_rd;
   assign ex_op_a   = w_op_a;
   assign ex_op_b   = w_op_b;
   assign Shift_In  = w_op_a;
   assign Shift_Val = r_imm;
   assign Mode      = (r_opcode == OP_SRA);

endmodule

// File: tb/tb_id_ex_shift_stage.sv
// Self-checking bench for id_ex_shift_stage: directed scenarios followed by
// randomized traffic compared against a transaction-level model.
module tb_id_ex_shift_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [3:0]  id_opcode;
   logic [15:0] id_rs_data, id_rt_data;
   logic [3:0]  id_rs, id_rt, id_rd, id_imm;
   logic        id_wr_en, stall, flush;
   logic [3:0]  exmem_rd, memwb_rd;
   logic        exmem_wr_en, memwb_wr_en;
   logic [15:0] exmem_result, memwb_result;
   logic        ex_valid, ex_wr_en, Mode;
   logic [3:0]  ex_opcode, ex_rd, Shift_Val;
   logic [15:0] ex_op_a, ex_op_b, Shift_In;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit        valid;
      bit        wr;
      bit [3:0]  opc;
      bit [3:0]  rd;
      bit [3:0]  rs;
      bit [3:0]  rt;
      bit [15:0] rsd;
      bit [15:0] rtd;
      bit [3:0]  imm;
   } instr_t;

   instr_t m;
   const instr_t bubble = '{default: 0};

   id_ex_shift_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_rs(id_rs),
      .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_wr_en(id_wr_en),
      .stall(stall), .flush(flush), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_wr_en(exmem_wr_en), .memwb_wr_en(memwb_wr_en),
      .exmem_result(exmem_result), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_opcode(ex_opcode),
      .ex_rd(ex_rd), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
      .Shift_In(Shift_In), .Shift_Val(Shift_Val), .Mode(Mode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Operand the EX stage should see for a source register, given the
   // later-stage results currently on the bus.
   function automatic bit [15:0] expect_op(input bit [3:0] r, input bit [15:0] d);
      if (r == 0) return d;
      if (exmem_wr_en && exmem_rd == r) return exmem_result;
      if (memwb_wr_en && memwb_rd == r) return memwb_result;
      return d;
   endfunction

   task automatic check_all(input string tag);
      bit [15:0] a;
      a = expect_op(m.rs, m.rsd);
      check({tag, ".valid"}, ex_valid, m.valid);
      check({tag, ".wr_en"}, ex_wr_en, m.wr);
      check({tag, ".opcode"}, ex_opcode, m.opc);
      check({tag, ".rd"}, ex_rd, m.rd);
      check({tag, ".op_a"}, ex_op_a, a);
      check({tag, ".op_b"}, ex_op_b, expect_op(m.rt, m.rtd));
      check({tag, ".shift_in"}, Shift_In, a);
      check({tag, ".shift_val"}, Shift_Val, m.imm);
      check({tag, ".mode"}, Mode, m.opc == 4'b0101);
   endtask

   // One clock edge: advance the model on what the DUT sampled, then check
   // mid-cycle.
   task automatic tick(input string tag);
      @(posedge clk);
      if (rst || flush) m = bubble;
      else if (!stall) begin
         m.valid = id_valid;
         m.wr    = id_valid && id_wr_en;
         m.opc   = id_opcode;
         m.rd    = id_rd;
         m.rs    = id_rs;
         m.rt    = id_rt;
         m.rsd   = id_rs_data;
         m.rtd   = id_rt_data;
         m.imm   = id_imm;
      end
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic no_fwd();
      exmem_wr_en = 0; memwb_wr_en = 0;
      exmem_rd = 0; memwb_rd = 0; exmem_result = 0; memwb_result = 0;
   endtask

   task automatic set_instr(input bit [3:0] opc, input bit [3:0] rs,
                            input bit [15:0] rsd, input bit [3:0] rt,
                            input bit [15:0] rtd, input bit [3:0] rd,
                            input bit [3:0] imm, input bit v, input bit w);
      id_opcode = opc; id_rs = rs; id_rs_data = rsd; id_rt = rt;
      id_rt_data = rtd; id_rd = rd; id_imm = imm; id_valid = v; id_wr_en = w;
   endtask

   initial begin
      m = bubble;
      rst = 1; stall = 0; flush = 0;
      set_instr(4'h0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0);
      no_fwd();
      #12;
      check_all("reset");
      @(negedge clk);
      rst = 0;

      // SRA capture
      set_instr(4'b0101, 3, 16'h8000, 2, 16'h1234, 7, 4, 1, 1);
      tick("capture");
      check("capture.mode_const", Mode, 1'b1);
      check("capture.shift_in_const", Shift_In, 16'h8000);

      // Forwarding priority
      set_instr(4'h1, 5, 16'hAAAA, 6, 16'hBBBB, 1, 2, 1, 1);
      exmem_rd = 5; exmem_wr_en = 1; exmem_result = 16'h1111;
      memwb_rd = 5; memwb_wr_en = 1; memwb_result = 16'h2222;
      tick("prio");
      check("prio.exmem", ex_op_a, 16'h1111);
      exmem_wr_en = 0;
      #1;
      check_all("prio_drop");
      check("prio.memwb", ex_op_a, 16'h2222);

      // Register 0 is never forwarded
      no_fwd();
      set_instr(4'h2, 0, 16'h0, 0, 16'h0, 3, 1, 1, 1);
      exmem_rd = 0; exmem_wr_en = 1; exmem_result = 16'hFFFF;
      tick("reg0");
      check("reg0.op_a", ex_op_a, 16'h0000);
      no_fwd();

      // Stall two cycles then flush with stall still high
      set_instr(4'b0101, 4, 16'hC0DE, 9, 16'h5A5A, 8, 3, 1, 1);
      tick("stall_cap");
      stall = 1;
      set_instr(4'h3, 1, 16'h1, 2, 16'h2, 2, 1, 1, 1);
      tick("stall1");
      tick("stall2");
      check("stall.hold_rd", ex_rd, 4'd8);
      flush = 1;
      tick("flush");
      check("flush.valid", ex_valid, 1'b0);
      flush = 0; stall = 0;

      // Async reset between edges, held instruction under stall
      set_instr(4'b0101, 6, 16'h7777, 5, 16'h6666, 4, 9, 1, 1);
      tick("pre_rst");
      stall = 1;
      #2;
      rst = 1;
      m = bubble;
      #1;
      check_all("async_rst");
      check("async_rst.valid", ex_valid, 1'b0);
      @(negedge clk);
      rst = 0; stall = 0;
      set_instr(4'h7, 2, 16'h0F0F, 3, 16'hF0F0, 6, 5, 1, 1);
      tick("post_rst");

      // Invalid capture suppresses write enable
      set_instr(4'h4, 1, 16'h1, 1, 16'h1, 5, 1, 0, 1);
      tick("invalid");
      check("invalid.wr_en", ex_wr_en, 1'b0);

      // Randomized traffic with narrow register ranges to provoke matches
      for (int i = 0; i < 400; i++) begin
         set_instr($urandom_range(0, 15), $urandom_range(0, 3), $urandom,
                   $urandom_range(0, 3), $urandom, $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) id_opcode = 4'b0101;
         stall        = ($urandom_range(0, 3) == 0);
         flush        = ($urandom_range(0, 9) == 0);
         exmem_rd     = $urandom_range(0, 3);
         memwb_rd     = $urandom_range(0, 3);
         exmem_wr_en  = $urandom_range(0, 1);
         memwb_wr_en  = $urandom_range(0, 1);
         exmem_result = $urandom;
         memwb_result = $urandom;
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
